// File: rtl/nios_system_tick_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nios_system_tick_counter_if : Avalon-MM slave bus plus interrupt line        |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface nios_system_tick_counter_if;
    logic        chipselect;
    logic [2:0]  address;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output chipselect, address, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  chipselect, address, write_n, writedata,
        output readdata, irq
    );
endinterface
`default_nettype wire

// File: rtl/nios_system_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nios_system_tick_counter : 32-bit tick counter with compare/overflow irq     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module nios_system_tick_counter (
    input  wire logic                   clk,
    input  wire logic                   reset_n,
    input  wire logic                   tick_in,
    nios_system_tick_counter_if.slave   bus
);

    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] c_ADDR_COUNT_L = 3'd2;
    localparam logic [2:0] c_ADDR_COUNT_H = 3'd3;
    localparam logic [2:0] c_ADDR_COMPARE = 3'd4;

    typedef enum logic [0:0] {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [31:0] r_count;
    logic [15:0] r_snap;
    logic [15:0] r_compare;
    logic        r_irq_en;
    logic        r_match;
    logic        r_overflow;
    logic [15:0] r_readdata;

    logic        w_wr;
    logic        w_rd;
    logic        w_ctrl_wr;
    logic        w_status_wr;
    logic        w_clear;
    logic        w_tick_event;
    logic        w_inc;
    logic [31:0] w_count_next;
    logic        w_set_ovf;
    logic        w_set_match;
    logic [15:0] w_rd_mux;

    assign w_wr         = bus.chipselect & ~bus.write_n;
    assign w_rd         = bus.chipselect &  bus.write_n;
    assign w_ctrl_wr    = w_wr & (bus.address == c_ADDR_CONTROL);
    assign w_status_wr  = w_wr & (bus.address == c_ADDR_STATUS);
    assign w_clear      = w_ctrl_wr & bus.writedata[2];
    assign w_tick_event = r_sync2 & ~r_prev;
    // A same-cycle clear suppresses the increment and any flag it would set.
    assign w_inc        = (r_state == ST_RUNNING) & w_tick_event & ~w_clear;
    assign w_count_next = r_count + 32'd1;
    assign w_set_ovf    = w_inc & (r_count == 32'hFFFF_FFFF);
    assign w_set_match  = w_inc & (w_count_next[15:0] == r_compare);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= tick_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_STOPPED;
            r_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_state  <= bus.writedata[1] ? ST_RUNNING : ST_STOPPED;
            r_irq_en <= bus.writedata[0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= 32'd0;
            r_snap     <= 16'd0;
            r_compare  <= 16'hFFFF;
            r_match    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_clear) begin
                r_count <= 32'd0;
            end else if (w_inc) begin
                r_count <= w_count_next;
            end

            if (w_rd && (bus.address == c_ADDR_COUNT_L)) begin
                r_snap <= r_count[31:16];
            end

            if (w_wr && (bus.address == c_ADDR_COMPARE)) begin
                r_compare <= bus.writedata;
            end

            if (w_set_match) begin
                r_match <= 1'b1;
            end else if (w_status_wr) begin
                r_match <= 1'b0;
            end

            if (w_set_ovf) begin
                r_overflow <= 1'b1;
            end else if (w_status_wr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    always_comb begin
        w_rd_mux = 16'd0;
        case (bus.address)
            c_ADDR_STATUS:  w_rd_mux = {13'd0, (r_state == ST_RUNNING), r_overflow, r_match};
            c_ADDR_CONTROL: w_rd_mux = {14'd0, (r_state == ST_RUNNING), r_irq_en};
            c_ADDR_COUNT_L: w_rd_mux = r_count[15:0];
            c_ADDR_COUNT_H: w_rd_mux = r_snap;
            c_ADDR_COMPARE: w_rd_mux = r_compare;
            default:        w_rd_mux = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 16'd0;
        end else begin
            r_readdata <= bus.chipselect ? w_rd_mux : 16'd0;
        end
    end

    assign bus.readdata = r_readdata;
    assign bus.irq      = r_irq_en & (r_match | r_overflow);

endmodule
`default_nettype wire

// File: tb/tb_nios_system_tick_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_nios_system_tick_counter : table + scoreboard bench for the tick counter  |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_nios_system_tick_counter;

    logic clk;
    logic reset_n;
    logic tick_in;

    nios_system_tick_counter_if bus_if();

    nios_system_tick_counter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .tick_in (tick_in),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;

    vec_t tbl[16];
    sb_t  sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic collect();
        sb_t s;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_empty: got no entry expected one");
        end else begin
            s = sb_q.pop_front();
            chk(s.name, {16'd0, bus_if.readdata}, {16'd0, s.exp});
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.address    = a;
        bus_if.writedata  = d;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [15:0] e, input string nm);
        @(negedge clk);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        bus_if.address    = a;
        sb_q.push_back('{nm, e});
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        collect();
    endtask

    task automatic pulse();
        @(negedge clk);
        tick_in = 1'b1;
        @(negedge clk);
        tick_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 16'h0000, 16'h0000};
        tbl[1]  = '{1'b0, 3'd1, 16'h0000, 16'h0000};
        tbl[2]  = '{1'b0, 3'd2, 16'h0000, 16'h0000};
        tbl[3]  = '{1'b0, 3'd3, 16'h0000, 16'h0000};
        tbl[4]  = '{1'b0, 3'd4, 16'h0000, 16'hFFFF};
        tbl[5]  = '{1'b0, 3'd5, 16'h0000, 16'h0000};
        tbl[6]  = '{1'b0, 3'd6, 16'h0000, 16'h0000};
        tbl[7]  = '{1'b0, 3'd7, 16'h0000, 16'h0000};
        tbl[8]  = '{1'b1, 3'd4, 16'hA5A5, 16'h0000};
        tbl[9]  = '{1'b0, 3'd4, 16'h0000, 16'hA5A5};
        tbl[10] = '{1'b1, 3'd5, 16'h1234, 16'h0000};
        tbl[11] = '{1'b0, 3'd5, 16'h0000, 16'h0000};
        tbl[12] = '{1'b1, 3'd4, 16'hFFFF, 16'h0000};
        tbl[13] = '{1'b1, 3'd1, 16'h0001, 16'h0000};
        tbl[14] = '{1'b0, 3'd1, 16'h0000, 16'h0001};
        tbl[15] = '{1'b1, 3'd1, 16'h0004, 16'h0000};

        reset_n           = 1'b0;
        tick_in           = 1'b0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.address    = 3'd0;
        bus_if.writedata  = 16'd0;
        repeat (3) @(negedge clk);
        chk("reset_readdata", {16'd0, bus_if.readdata}, 32'd0);
        chk("reset_irq", {31'd0, bus_if.irq}, 32'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
            else           bus_read(tbl[i].addr, tbl[i].exp, $sformatf("table_%0d", i));
        end
        bus_read(3'd1, 16'h0000, "ctrl_clear_bit_reads0");

        // Run and count five ticks.
        bus_write(3'd1, 16'h0002);
        repeat (5) pulse();
        bus_read(3'd2, 16'h0005, "count_after_5");
        bus_read(3'd0, 16'h0004, "status_running");

        // Two-edge latency from synchronizer input to count.
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1; bus_if.address = 3'd2;
        sb_q.push_back('{"latency_before", 16'h0005});
        @(negedge clk); collect();
        sb_q.push_back('{"latency_after", 16'h0006});
        @(negedge clk); bus_if.chipselect = 1'b0; collect();

        // Long high level counts once; stopped ignores ticks.
        @(negedge clk); tick_in = 1'b1;
        repeat (20) @(negedge clk);
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        bus_read(3'd2, 16'h0007, "held_high_once");
        bus_write(3'd1, 16'h0000);
        repeat (3) pulse();
        bus_read(3'd2, 16'h0007, "stopped_ignores");
        bus_read(3'd0, 16'h0000, "status_stopped");

        // Compare match raises irq, STATUS write clears it.
        bus_write(3'd1, 16'h0004);
        bus_write(3'd4, 16'h0003);
        bus_write(3'd1, 16'h0003);
        repeat (3) pulse();
        chk("irq_on_match", {31'd0, bus_if.irq}, 32'd1);
        bus_read(3'd0, 16'h0005, "status_match");
        bus_write(3'd0, 16'h0000);
        chk("irq_cleared", {31'd0, bus_if.irq}, 32'd0);
        bus_read(3'd0, 16'h0004, "status_after_clear");

        // Wrap from all ones, with snapshot checks.
        bus_write(3'd1, 16'h0004);
        bus_write(3'd1, 16'h0002);
        bus_write(3'd0, 16'h0000);
        @(negedge clk); force dut.r_count = 32'hFFFF_FFFF;
        @(negedge clk); release dut.r_count;
        bus_read(3'd2, 16'hFFFF, "preload_low");
        bus_read(3'd3, 16'hFFFF, "preload_snap");
        pulse();
        bus_read(3'd0, 16'h0006, "status_overflow");
        chk("irq_masked", {31'd0, bus_if.irq}, 32'd0);
        bus_write(3'd1, 16'h0003);
        chk("irq_overflow", {31'd0, bus_if.irq}, 32'd1);
        bus_read(3'd2, 16'h0000, "wrap_low");
        bus_read(3'd3, 16'h0000, "wrap_snap");

        // STATUS write coincides with match set.
        bus_write(3'd1, 16'h0006);
        bus_write(3'd0, 16'h0000);
        repeat (2) pulse();
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        bus_if.address = 3'd0; bus_if.writedata = 16'h0000;
        @(negedge clk); bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
        bus_read(3'd0, 16'h0005, "match_wins_clear");
        bus_read(3'd2, 16'h0003, "count_at_match");

        // CONTROL clear coincides with a tick.
        @(negedge clk); tick_in = 1'b1;
        @(negedge clk); tick_in = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        bus_if.address = 3'd1; bus_if.writedata = 16'h0006;
        @(negedge clk); bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1;
        bus_if.address = 3'd2;
        sb_q.push_back('{"clear_wins_tick", 16'h0000});
        @(negedge clk); bus_if.chipselect = 1'b0; collect();

        // Clearing to zero never sets match, even with COMPARE zero.
        bus_write(3'd0, 16'h0000);
        bus_write(3'd4, 16'h0000);
        bus_write(3'd1, 16'h0006);
        bus_read(3'd0, 16'h0004, "clear_no_match");

        // Mid-run asynchronous reset at count 0x1234.
        bus_write(3'd4, 16'h1000);
        bus_write(3'd1, 16'h0006);
        repeat (16'h1234) pulse();
        bus_write(3'd1, 16'h0003);
        chk("irq_before_reset", {31'd0, bus_if.irq}, 32'd1);
        @(negedge clk);
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b1; bus_if.address = 3'd2;
        @(negedge clk);
        chk("count_before_reset", {16'd0, bus_if.readdata}, 32'h1234);
        #3;
        reset_n = 1'b0;
        tick_in = 1'b1;
        #1;
        chk("async_reset_readdata", {16'd0, bus_if.readdata}, 32'd0);
        chk("async_reset_irq", {31'd0, bus_if.irq}, 32'd0);
        bus_if.chipselect = 1'b0;

        // Tick already high at release counts once after the synchronizer fills.
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0;
        bus_if.address = 3'd1; bus_if.writedata = 16'h0002;
        @(negedge clk);
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
        repeat (10) @(negedge clk);
        bus_read(3'd2, 16'h0001, "high_at_release");
        bus_read(3'd4, 16'hFFFF, "compare_after_reset");
        bus_read(3'd3, 16'h0000, "snap_after_reset");
        bus_read(3'd0, 16'h0004, "status_after_reset");
        tick_in = 1'b0;

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/nios_system_tick_counter.md
NIOS_SYSTEM_TICK_COUNTER -- requirements
Module: nios_system_tick_counter

Interface
REQ-001 SHALL have these ports: clk, input, 1, single system clock, all state on rising edge.
REQ-002 SHALL have this port: reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have this port: tick_in, input, 1, periodic interval-timer interrupt level; asynchronous to the bus view, so it is synchronized.
REQ-004 SHALL have this port: chipselect, input, 1, Avalon-MM slave select.
REQ-005 SHALL have this port: address, input, 3, register index.
REQ-006 SHALL have this port: write_n, input, 1, active-low write; chipselect with write_n=1 is a read.
REQ-007 SHALL have this port: writedata, input, 16, write data.
REQ-008 SHALL have this port: readdata, output, 16, registered read data, reset 0.
REQ-009 SHALL have this port: irq, output, 1, level interrupt, reset 0.

Function
REQ-010 Register map SHALL be: 0 STATUS {bit2 running, bit1 overflow, bit0 match}; 1 CONTROL {bit1 run, bit0 irq_en}; 2 COUNT_L; 3 COUNT_H_SNAP; 4 COMPARE; 5-7 read 0, writes ignored.
REQ-011 tick_in SHALL pass through a 2-flop synchronizer followed by a previous-value flop; tick_event = sync2 & ~prev.
REQ-012 tick_event SHALL be true for exactly one cycle per low-to-high tick_in transition; a tick_in high level held for multiple cycles SHALL count once.
REQ-013 The FSM SHALL have states STOPPED and RUNNING; reset enters STOPPED.
REQ-014 A CONTROL write with bit1=1 SHALL move the FSM to RUNNING; bit1=0 SHALL move it to STOPPED; the new state is effective the cycle after the write.
REQ-015 In RUNNING, each tick_event SHALL increment a 32-bit count by 1; in STOPPED, tick_events SHALL be ignored.
REQ-016 Latency: a tick_in rising edge sampled at clock edge N SHALL be visible in count after clock edge N+2.
REQ-017 Count SHALL wrap from 0xFFFFFFFF to 0x00000000 and set overflow on that increment.
REQ-018 A CONTROL write with bit2=1 SHALL clear count to 0 (bit2 is self-clearing and reads 0); the clear SHALL win over a same-cycle tick_event.
REQ-019 match SHALL set when an increment makes count[15:0] equal to COMPARE; clearing count to 0 SHALL NOT set match.
REQ-020 A write of any value to STATUS SHALL clear match and overflow; a same-cycle set event SHALL win, leaving the flag at 1.
REQ-021 A read of COUNT_L (chipselect, write_n=1, address=2) SHALL load COUNT_H_SNAP with count[31:16] at the same edge; COUNT_H_SNAP SHALL change only on that read.
REQ-022 readdata SHALL be registered each clock from the addressed register, giving one cycle read latency; with chipselect low it SHALL load 0.
REQ-023 irq SHALL be irq_en & (match | overflow), driven from registered state only.
REQ-024 COMPARE SHALL be fully writable and readable; its reset value SHALL be 0xFFFF.

Reset
REQ-025 Asserting reset_n=0 at any time, including mid-count, SHALL immediately set: count 0, snapshot 0, COMPARE 0xFFFF, CONTROL 0, flags 0, synchronizer flops 0, FSM STOPPED, readdata 0, irq 0.
REQ-026 After reset release, a tick_in already high SHALL produce one tick_event once the synchronizer fills.

Verification
REQ-027 Reset, write CONTROL=0x0002, then pulse tick_in 5 times -> COUNT_L reads 0x0005 and STATUS reads 0x0004.
REQ-028 Hold tick_in high for 20 cycles -> count increments by exactly 1; in STOPPED, 3 pulses -> count unchanged.
REQ-029 Set COMPARE=0x0003 with CONTROL=0x0003, then send 3 ticks -> irq=1 and STATUS=0x0005; write STATUS -> irq=0 the next cycle.
REQ-030 Force count to 0xFFFFFFFF via ticks (or preload in the bench), then send 1 tick -> count=0, overflow=1; read COUNT_L, then COUNT_H_SNAP -> 0x0000, 0x0000.
REQ-031 Make a STATUS write coincide with a match event -> match remains 1; make CONTROL bit2 coincide with a tick -> count=0.
REQ-032 Assert reset_n mid-run with count=0x1234 -> all outputs 0 and COMPARE=0xFFFF without waiting for a clock edge.
